// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pipe_pkg
// Description : Shared types and constants for the MIPS pipeline sequencing
//               logic (mult/div FSM state encoding, zero register, default
//               mult/div latency).
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

    // Mult/div occupancy FSM states
    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Architectural zero register; never a real dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default mult/div execution latency in cycles
    localparam int MD_LATENCY_DEFAULT = 32;

endpackage
`default_nettype wire

// File: rtl/md_occupancy_tracker.sv
`default_nettype none
// ============================================================================
// Module      : md_occupancy_tracker
// Description : Tracks occupancy of the multi-cycle mult/div unit. A start
//               pulse moves the FSM to BUSY for exactly MD_LATENCY cycles;
//               md_done marks the final cycle when HI/LO are written.
// Revision    : 1.0 - initial release
// ============================================================================
module md_occupancy_tracker
    import mips_pipe_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    output logic md_busy,
    output logic md_done
);

    // Counter only needs to hold MD_LATENCY-1 down to 0
    localparam int            c_CW   = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam logic [c_CW-1:0] c_LOAD = c_CW'(MD_LATENCY - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    md_state_t         r_state;
    md_state_t         w_state_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cnt_nxt;

    // State and latency counter registers; reset aborts any in-flight op
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: start loads the counter, BUSY counts down to the done cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            MD_IDLE: begin
                if (md_start) begin
                    w_state_nxt = MD_BUSY;
                    w_cnt_nxt   = c_LOAD;
                end
            end
            MD_BUSY: begin
                // A start while busy cannot be legitimate and is ignored
                if (r_cnt == '0) begin
                    w_state_nxt = MD_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_ONE;
                end
            end
            default: begin
                w_state_nxt = MD_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign md_busy = (r_state == MD_BUSY);
    assign md_done = (r_state == MD_BUSY) && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_controller
// Description : Pipeline sequencing controller. Detects load-use, taken-branch
//               and mult/div-occupancy hazards and drives PC / IF-ID write
//               enables, IF/ID flush and ID/EX bubble insertion.
//               Optional macro HAZARD_PERF_CNT_EN builds saturating stall and
//               flush performance counters; otherwise they read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_controller
    import mips_pipe_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_write_reg_addr,
    input  logic [4:0]       if_id_instr_rs,
    input  logic [4:0]       if_id_instr_rt,
    input  logic             if_id_uses_rt,
    input  logic             if_id_uses_md,
    input  logic             ex_branch_taken,
    input  logic             ex_md_start,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    logic w_load_use;
    logic w_md_hazard;

    md_occupancy_tracker #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_start (ex_md_start),
        .md_busy  (md_busy),
        .md_done  (md_done)
    );

    // A load into $0 never creates a dependency
    assign w_load_use = id_ex_mem_read
                      && (id_ex_write_reg_addr != REG_ZERO)
                      && ((id_ex_write_reg_addr == if_id_instr_rs)
                          || (if_id_uses_rt && (id_ex_write_reg_addr == if_id_instr_rt)));

    // HI/LO consumers wait through the done cycle as well
    assign w_md_hazard = md_busy && if_id_uses_md;

    // Prioritised enables: reset, then branch squash, then stall, else flow
    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        if (!rst_n) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (w_load_use || w_md_hazard) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    // Saturating performance counters; they hold at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!pc_write_en && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + c_CNT_ONE;
            end
            if (if_id_flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + c_CNT_ONE;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_controller
// Description : Directed self-checking bench for hazard_stall_controller
//               (MD_LATENCY=4, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_controller;

    localparam int c_LAT   = 4;
    localparam int c_CNT_W = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam logic c_PERF = 1'b1;
`else
    localparam logic c_PERF = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               id_ex_mem_read;
    logic [4:0]         id_ex_write_reg_addr;
    logic [4:0]         if_id_instr_rs;
    logic [4:0]         if_id_instr_rt;
    logic               if_id_uses_rt;
    logic               if_id_uses_md;
    logic               ex_branch_taken;
    logic               ex_md_start;
    logic               pc_write_en;
    logic               if_id_write_en;
    logic               if_id_flush;
    logic               id_ex_bubble;
    logic               md_busy;
    logic               md_done;
    logic [c_CNT_W-1:0] stall_cycles;
    logic [c_CNT_W-1:0] flush_count;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_stall_controller #(
        .MD_LATENCY (c_LAT),
        .CNT_W      (c_CNT_W)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .id_ex_mem_read       (id_ex_mem_read),
        .id_ex_write_reg_addr (id_ex_write_reg_addr),
        .if_id_instr_rs       (if_id_instr_rs),
        .if_id_instr_rt       (if_id_instr_rt),
        .if_id_uses_rt        (if_id_uses_rt),
        .if_id_uses_md        (if_id_uses_md),
        .ex_branch_taken      (ex_branch_taken),
        .ex_md_start          (ex_md_start),
        .pc_write_en          (pc_write_en),
        .if_id_write_en       (if_id_write_en),
        .if_id_flush          (if_id_flush),
        .id_ex_bubble         (id_ex_bubble),
        .md_busy              (md_busy),
        .md_done              (md_done),
        .stall_cycles         (stall_cycles),
        .flush_count          (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the four pipeline enables at once
    task automatic check_ctl(input string tag, input logic pc, input logic ifid,
                             input logic fl, input logic bub);
        #1;
        check({tag, ".pc_write_en"},    pc_write_en,    pc);
        check({tag, ".if_id_write_en"}, if_id_write_en, ifid);
        check({tag, ".if_id_flush"},    if_id_flush,    fl);
        check({tag, ".id_ex_bubble"},   id_ex_bubble,   bub);
    endtask

    task automatic idle_inputs();
        id_ex_mem_read       = 1'b0;
        id_ex_write_reg_addr = 5'd0;
        if_id_instr_rs       = 5'd0;
        if_id_instr_rt       = 5'd0;
        if_id_uses_rt        = 1'b0;
        if_id_uses_md        = 1'b0;
        ex_branch_taken      = 1'b0;
        ex_md_start          = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();

        // Reset state
        check_ctl("reset", 1'b0, 1'b0, 1'b1, 1'b1);
        check("reset.md_busy",      md_busy,      0);
        check("reset.md_done",      md_done,      0);
        check("reset.stall_cycles", stall_cycles, 0);
        check("reset.flush_count",  flush_count,  0);

        rst_n = 1'b1;
        check_ctl("idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // lw $3 in EX, ID add $4,$3,$5: one stall cycle
        id_ex_mem_read = 1'b1; id_ex_write_reg_addr = 5'd3;
        if_id_instr_rs = 5'd3; if_id_instr_rt = 5'd5; if_id_uses_rt = 1'b1;
        check_ctl("lu_rs", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        id_ex_mem_read = 1'b0;                 // EX now holds the bubble
        check_ctl("lu_release", 1'b1, 1'b1, 1'b0, 1'b0);

        // Dependency through rt
        id_ex_mem_read = 1'b1; if_id_instr_rs = 5'd7; if_id_instr_rt = 5'd3;
        check_ctl("lu_rt", 1'b0, 1'b0, 1'b0, 1'b1);

        // lw $0: never a hazard
        id_ex_write_reg_addr = 5'd0; if_id_instr_rs = 5'd0; if_id_instr_rt = 5'd0;
        check_ctl("lu_zero", 1'b1, 1'b1, 1'b0, 1'b0);

        // rt matches but is not a source
        id_ex_write_reg_addr = 5'd3; if_id_instr_rs = 5'd8; if_id_instr_rt = 5'd3;
        if_id_uses_rt = 1'b0;
        check_ctl("lu_no_rt", 1'b1, 1'b1, 1'b0, 1'b0);

        // Branch wins over a load-use stall
        if_id_uses_rt = 1'b1; ex_branch_taken = 1'b1;
        check_ctl("br_over_lu", 1'b1, 1'b1, 1'b1, 1'b1);
        idle_inputs();
        tick();

        // Mult/div: start sampled at edge t, dependent mflo held until t+5
        ex_md_start = 1'b1;
        #1;
        check("md_pre.md_busy", md_busy, 0);
        tick();                                // edge t
        ex_md_start   = 1'b0;
        if_id_uses_md = 1'b1;
        for (int k = 1; k <= c_LAT; k++) begin
            #1;
            check($sformatf("md_c%0d.md_busy", k), md_busy, 1);
            check($sformatf("md_c%0d.md_done", k), md_done, (k == c_LAT) ? 1 : 0);
            check($sformatf("md_c%0d.pc_write_en", k), pc_write_en, 0);
            tick();
        end
        check_ctl("md_release", 1'b1, 1'b1, 1'b0, 1'b0);
        check("md_release.md_busy", md_busy, 0);
        idle_inputs();

        // Reset in the middle of a mult/div; independent ID instr flows first
        ex_md_start = 1'b1;
        tick();                                // edge t
        ex_md_start = 1'b0;
        check_ctl("md_indep", 1'b1, 1'b1, 1'b0, 1'b0);
        check("md_indep.md_busy", md_busy, 1);
        tick();                                // edge t+1
        rst_n = 1'b0;
        check_ctl("md_rst_comb", 1'b0, 1'b0, 1'b1, 1'b1);
        tick();                                // edge t+2 samples reset
        check("md_rst.md_busy", md_busy, 0);
        rst_n = 1'b1;
        for (int k = 0; k < c_LAT + 2; k++) begin
            tick();
            check($sformatf("md_abort%0d.md_done", k), md_done, 0);
            check($sformatf("md_abort%0d.md_busy", k), md_busy, 0);
        end

        // Perf counters: clear, 20 stall cycles, then 3 branch flushes
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        id_ex_mem_read = 1'b1; id_ex_write_reg_addr = 5'd9; if_id_instr_rs = 5'd9;
        for (int k = 0; k < 20; k++) tick();
        idle_inputs();
        tick();
        check("perf.stall_sat", stall_cycles, c_PERF ? 15 : 0);
        check("perf.flush_zero", flush_count, 0);
        ex_branch_taken = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        ex_branch_taken = 1'b0;
        tick();
        check("perf.stall_hold", stall_cycles, c_PERF ? 15 : 0);
        check("perf.flush_3",    flush_count,  c_PERF ? 3 : 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
